// File: rtl/mont_seq_pkg.sv
`default_nettype none
// ============================================================================
// mont_seq_pkg : opcodes, FSM encoding and default widths shared by the
//                Montgomery command sequencer.
// Revision     : 1.0
// ============================================================================
package mont_seq_pkg;

    localparam int unsigned c_data_width   = 1024;
    localparam int unsigned c_cmd_width    = 32;
    localparam int unsigned c_core_timeout = 4096;
    localparam int unsigned c_op_width     = 4;

    localparam logic [c_op_width-1:0] c_op_nop      = 4'h0;
    localparam logic [c_op_width-1:0] c_op_load_a   = 4'h1;
    localparam logic [c_op_width-1:0] c_op_load_b   = 4'h2;
    localparam logic [c_op_width-1:0] c_op_load_m   = 4'h3;
    localparam logic [c_op_width-1:0] c_op_mult     = 4'h4;
    localparam logic [c_op_width-1:0] c_op_read_res = 4'h5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DECODE   = 3'd1,
        ST_WAIT_DIN = 3'd2,
        ST_START    = 3'd3,
        ST_BUSY     = 3'd4,
        ST_WRITE    = 3'd5,
        ST_ACK      = 3'd6
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mont_seq_watchdog.sv
`default_nettype none
// ============================================================================
// mont_seq_watchdog : core-latency budget counter, loaded at launch and
//                     decremented while the core runs.
// Revision          : 1.0
// ============================================================================
module mont_seq_watchdog #(
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_run,
    output logic o_expired
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // count holds the cycles still allowed, including the current one; the
    // launch cycle itself consumes one unit of the budget.
    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = CNT_W'(TIMEOUT - 1);
        end else if (i_run && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_expired = i_run && (count_q <= CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/mont_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// mont_cmd_sequencer : decodes port1 commands, stages operands, runs the
//                      Montgomery core and returns results/acks.
// Revision           : 1.0
// ============================================================================
module mont_cmd_sequencer
    import mont_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = c_data_width,
    parameter int unsigned CMD_WIDTH    = c_cmd_width,
    parameter int unsigned CORE_TIMEOUT = c_core_timeout
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CMD_WIDTH-1:0]  port1_din,
    input  logic                  port1_valid,
    output logic                  port1_read,
    output logic                  port2_valid,
    input  logic                  port2_read,
    input  logic [DATA_WIDTH-1:0] bram_din,
    input  logic                  bram_din_valid,
    output logic [DATA_WIDTH-1:0] bram_dout,
    output logic                  bram_dout_valid,
    input  logic                  bram_dout_read,
    output logic [DATA_WIDTH-1:0] core_a,
    output logic [DATA_WIDTH-1:0] core_b,
    output logic [DATA_WIDTH-1:0] core_m,
    output logic                  core_start,
    input  logic                  core_done,
    input  logic [DATA_WIDTH-1:0] core_result,
    output logic                  cmd_error,
    output logic                  busy,
    output logic [31:0]           cycle_count
);

    state_e                  state_q, state_d;
    logic [c_op_width-1:0]   opcode_q, opcode_d;
    logic                    cmd_error_q, cmd_error_d;
    logic [2:0]              loaded_q, loaded_d;
    logic                    result_valid_q, result_valid_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic [DATA_WIDTH-1:0]   m_q, m_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic [31:0]             cycle_count_q, cycle_count_d;
    logic                    core_start_q, core_start_d;

    logic                    w_accept;
    logic                    w_wd_load;
    logic                    w_wd_run;
    logic                    w_wd_expired;
    logic                    w_unused_cmd_bits;

    assign w_unused_cmd_bits = ^port1_din[CMD_WIDTH-1:c_op_width];

    assign w_wd_load = (state_q == ST_START);
    assign w_wd_run  = (state_q == ST_BUSY);

    mont_seq_watchdog #(
        .TIMEOUT (CORE_TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_wd_load),
        .i_run     (w_wd_run),
        .o_expired (w_wd_expired)
    );

    assign w_accept = (state_q == ST_IDLE) && port1_valid && !port2_valid && !reset;

    always_comb begin
        state_d        = state_q;
        opcode_d       = opcode_q;
        cmd_error_d    = cmd_error_q;
        loaded_d       = loaded_q;
        result_valid_d = result_valid_q;
        a_d            = a_q;
        b_d            = b_q;
        m_d            = m_q;
        result_d       = result_q;
        cycle_count_d  = cycle_count_q;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    opcode_d    = port1_din[c_op_width-1:0];
                    cmd_error_d = 1'b0;
                    state_d     = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (opcode_q)
                    c_op_load_a, c_op_load_b, c_op_load_m: begin
                        state_d = ST_WAIT_DIN;
                    end
                    c_op_mult: begin
                        if (&loaded_q) begin
                            state_d = ST_START;
                        end else begin
                            cmd_error_d = 1'b1;
                            state_d     = ST_ACK;
                        end
                    end
                    c_op_read_res: begin
                        if (result_valid_q) begin
                            state_d = ST_WRITE;
                        end else begin
                            cmd_error_d = 1'b1;
                            state_d     = ST_ACK;
                        end
                    end
                    c_op_nop: begin
                        state_d = ST_ACK;
                    end
                    default: begin
                        cmd_error_d = 1'b1;
                        state_d     = ST_ACK;
                    end
                endcase
            end
            ST_WAIT_DIN: begin
                if (bram_din_valid) begin
                    // Only LOAD opcodes reach this state, so the default is LOAD_M.
                    case (opcode_q)
                        c_op_load_a: begin
                            a_d         = bram_din;
                            loaded_d[0] = 1'b1;
                        end
                        c_op_load_b: begin
                            b_d         = bram_din;
                            loaded_d[1] = 1'b1;
                        end
                        default: begin
                            m_d         = bram_din;
                            loaded_d[2] = 1'b1;
                        end
                    endcase
                    state_d = ST_ACK;
                end
            end
            ST_START: begin
                result_valid_d = 1'b0;
                cycle_count_d  = 32'd1;
                state_d        = ST_BUSY;
            end
            ST_BUSY: begin
                if (cycle_count_q != 32'hFFFF_FFFF) begin
                    cycle_count_d = cycle_count_q + 32'd1;
                end
                if (core_done) begin
                    result_d       = core_result;
                    result_valid_d = 1'b1;
                    state_d        = ST_ACK;
                end else if (w_wd_expired) begin
                    cmd_error_d = 1'b1;
                    state_d     = ST_ACK;
                end
            end
            ST_WRITE: begin
                if (bram_dout_read) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (port2_read) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered so the launch pulse comes straight off a flop.
        core_start_d = (state_d == ST_START);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            opcode_q       <= '0;
            cmd_error_q    <= 1'b0;
            loaded_q       <= '0;
            result_valid_q <= 1'b0;
            a_q            <= '0;
            b_q            <= '0;
            m_q            <= '0;
            result_q       <= '0;
            cycle_count_q  <= '0;
            core_start_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            opcode_q       <= opcode_d;
            cmd_error_q    <= cmd_error_d;
            loaded_q       <= loaded_d;
            result_valid_q <= result_valid_d;
            a_q            <= a_d;
            b_q            <= b_d;
            m_q            <= m_d;
            result_q       <= result_d;
            cycle_count_q  <= cycle_count_d;
            core_start_q   <= core_start_d;
        end
    end

    assign port1_read      = w_accept;
    assign port2_valid     = (state_q == ST_ACK);
    assign bram_dout       = result_q;
    assign bram_dout_valid = (state_q == ST_WRITE);
    assign core_a          = a_q;
    assign core_b          = b_q;
    assign core_m          = m_q;
    assign core_start      = core_start_q;
    assign cmd_error       = cmd_error_q;
    assign busy            = (state_q != ST_IDLE);
    assign cycle_count     = cycle_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mont_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// tb_mont_cmd_sequencer : directed self-checking bench with a core model and
//                         an expected-completion scoreboard.
// Revision              : 1.0
// ============================================================================
module tb_mont_cmd_sequencer;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_LOAD_A = 4'h1;
    localparam logic [3:0] OP_LOAD_B = 4'h2;
    localparam logic [3:0] OP_LOAD_M = 4'h3;
    localparam logic [3:0] OP_MULT   = 4'h4;
    localparam logic [3:0] OP_READ   = 4'h5;
    localparam logic [3:0] OP_ILL    = 4'hF;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   port1_din = '0;
    logic          port1_valid = 1'b0;
    logic          port1_read;
    logic          port2_valid;
    logic          port2_read = 1'b0;
    logic [1023:0] bram_din = '0;
    logic          bram_din_valid = 1'b0;
    logic [1023:0] bram_dout;
    logic          bram_dout_valid;
    logic          bram_dout_read = 1'b0;
    logic [1023:0] core_a, core_b, core_m;
    logic          core_start;
    logic          core_done = 1'b0;
    logic [1023:0] core_result = 1024'h2;
    logic          cmd_error;
    logic          busy;
    logic [31:0]   cycle_count;

    mont_cmd_sequencer #(
        .DATA_WIDTH   (1024),
        .CMD_WIDTH    (32),
        .CORE_TIMEOUT (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .port1_din       (port1_din),
        .port1_valid     (port1_valid),
        .port1_read      (port1_read),
        .port2_valid     (port2_valid),
        .port2_read      (port2_read),
        .bram_din        (bram_din),
        .bram_din_valid  (bram_din_valid),
        .bram_dout       (bram_dout),
        .bram_dout_valid (bram_dout_valid),
        .bram_dout_read  (bram_dout_read),
        .core_a          (core_a),
        .core_b          (core_b),
        .core_m          (core_m),
        .core_start      (core_start),
        .core_done       (core_done),
        .core_result     (core_result),
        .cmd_error       (cmd_error),
        .busy            (busy),
        .cycle_count     (cycle_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cmds = 0;
    int cyc = 0;
    int t_acc = 0, p2_cyc = 0, start_cyc = 0, done_cyc = 0, r_cyc = 0;
    int p1r_cnt = 0, p1r_during_p2 = 0, start_cnt = 0, double_start = 0, p2_rise = 0;
    logic prev_start = 1'b0, prev_p2 = 1'b0;
    int core_lat = 0;
    int core_cnt = 0;

    logic          err_q[$];
    logic [1023:0] res_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (port1_read) p1r_cnt++;
        if (port1_read && port2_valid) p1r_during_p2++;
        if (core_start) begin
            start_cnt++;
            start_cyc = cyc;
        end
        if (core_start && prev_start) double_start++;
        prev_start = core_start;
        if (port2_valid && !prev_p2) begin
            p2_rise++;
            p2_cyc = cyc;
        end
        prev_p2 = port2_valid;
    end

    // Core model: done pulse core_lat cycles after start, inclusive.
    always @(negedge clk) begin
        core_done = 1'b0;
        if (reset) core_cnt = 0;
        else if (core_start) core_cnt = 1;
        else if (core_cnt != 0) core_cnt = core_cnt + 1;
        if (core_lat != 0 && core_cnt == core_lat) begin
            core_done = 1'b1;
            done_cyc  = cyc;
            core_cnt  = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "bench timeout");
    end

    task automatic drive();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic exp_err);
        err_q.push_back(exp_err);
        cmds++;
        drive();
        port1_din   = {28'hABCDEF0, op};
        port1_valid = 1'b1;
    endtask

    task automatic await_accept(input bit keep);
        int n;
        n = 0;
        sample();
        while (!port1_read && n < 50) begin
            sample();
            n++;
        end
        check("port1_read", port1_read, 1'b1);
        t_acc = cyc;
        if (!keep) begin
            drive();
            port1_valid = 1'b0;
        end
    endtask

    task automatic finish_cmd(input int rd_delay, input bit drop_valid);
        int   n;
        logic exp_err;
        n = 0;
        sample();
        while (!port2_valid && n < 200) begin
            sample();
            n++;
        end
        check("port2_valid", port2_valid, 1'b1);
        exp_err = (err_q.size() != 0) ? err_q.pop_front() : 1'bx;
        check("cmd_error", cmd_error, exp_err);
        repeat (rd_delay) drive();
        drive();
        port2_read = 1'b1;
        if (drop_valid) port1_valid = 1'b0;
        drive();
        port2_read = 1'b0;
    endtask

    task automatic load_op(input logic [3:0] op, input logic [1023:0] val);
        bram_din       = val;
        bram_din_valid = 1'b1;
        issue(op, 1'b0);
        await_accept(1'b0);
        finish_cmd(0, 1'b0);
        check("load_latency", p2_cyc - t_acc, 3);
        bram_din_valid = 1'b0;
    endtask

    initial begin
        int            n;
        int            s0;
        int            p1_before;
        logic [1023:0] exp_res;

        // Reset state
        repeat (3) drive();
        sample();
        check("reset_ctrl", {port1_read, port2_valid, bram_dout_valid, core_start, cmd_error, busy}, 6'b0);
        check("reset_cycle_count", cycle_count, 0);
        drive();
        reset = 1'b0;

        // Operand loads
        load_op(OP_LOAD_A, 1024'h5);
        load_op(OP_LOAD_B, 1024'h7);
        load_op(OP_LOAD_M, 1024'hB);
        check("core_a", core_a, 1024'h5);
        check("core_b", core_b, 1024'h7);
        check("core_m", core_m, 1024'hB);

        // MULT, core done 10 cycles start..done inclusive
        core_lat = 10;
        s0 = start_cnt;
        issue(OP_MULT, 1'b0);
        await_accept(1'b0);
        finish_cmd(0, 1'b0);
        check("mult_start_count", start_cnt - s0, 1);
        check("mult_start_latency", start_cyc - t_acc, 2);
        check("mult_ack_latency", p2_cyc - done_cyc, 1);
        check("cycle_count", cycle_count, 10);

        // READ_RES with delayed bram_dout_read
        issue(OP_READ, 1'b0);
        res_q.push_back(1024'h2);
        await_accept(1'b0);
        n = 0;
        sample();
        while (!bram_dout_valid && n < 50) begin
            sample();
            n++;
        end
        check("dout_valid_latency", cyc - t_acc, 2);
        exp_res = res_q.pop_front();
        check("bram_dout", bram_dout, exp_res);
        repeat (3) begin
            sample();
            check("dout_hold_valid", bram_dout_valid, 1'b1);
            check("dout_hold_data", bram_dout, exp_res);
        end
        drive();
        bram_dout_read = 1'b1;
        r_cyc = cyc;
        drive();
        bram_dout_read = 1'b0;
        sample();
        check("dout_valid_drop", bram_dout_valid, 1'b0);
        check("p2_after_dout", p2_cyc, r_cyc + 1);
        finish_cmd(0, 1'b0);

        // Watchdog abort; the core's late done must be ignored
        core_lat = 20;
        issue(OP_MULT, 1'b1);
        await_accept(1'b0);
        finish_cmd(0, 1'b0);
        check("timeout_ack", p2_cyc - start_cyc, 16);
        issue(OP_READ, 1'b1);
        await_accept(1'b0);
        finish_cmd(0, 1'b0);
        core_lat = 0;

        // Illegal opcode then NOP clears error
        issue(OP_ILL, 1'b1);
        await_accept(1'b0);
        finish_cmd(0, 1'b0);
        issue(OP_NOP, 1'b0);
        await_accept(1'b0);
        finish_cmd(0, 1'b0);

        // port1_valid held high, port2_read delayed
        p1_before = p1r_cnt;
        issue(OP_NOP, 1'b0);
        await_accept(1'b1);
        finish_cmd(5, 1'b0);
        err_q.push_back(1'b0);
        cmds++;
        finish_cmd(5, 1'b1);
        check("held_accepts", p1r_cnt - p1_before, 2);
        check("accept_during_p2", p1r_during_p2, 0);

        // Reset mid-BUSY
        issue(OP_MULT, 1'b0);
        await_accept(1'b0);
        repeat (4) sample();
        check("busy_before_reset", busy, 1'b1);
        drive();
        reset = 1'b1;
        sample();
        check("rst_ctrl", {port1_read, port2_valid, bram_dout_valid, core_start, cmd_error, busy}, 6'b0);
        check("rst_cycle_count", cycle_count, 0);
        check("rst_data", core_a | core_b | core_m | bram_dout, 0);
        err_q.delete();
        cmds--;
        drive();
        reset = 1'b0;

        s0 = start_cnt;
        issue(OP_MULT, 1'b1);
        await_accept(1'b0);
        finish_cmd(0, 1'b0);
        load_op(OP_LOAD_A, 1024'h5);
        load_op(OP_LOAD_B, 1024'h7);
        issue(OP_MULT, 1'b1);
        await_accept(1'b0);
        finish_cmd(0, 1'b0);
        check("no_start_unloaded", start_cnt - s0, 0);

        repeat (3) sample();
        check("p2_pulses_per_cmd", p2_rise, cmds);
        check("core_start_width", double_start, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
